multicycle_control_fsm: RTL and testbench

Sequencing controller for the multi-cycle RV32I core variant, sharing one memory and one ALU across fetch, address and execute phases. A Moore FSM steps each instruction through FETCH/DECODE/execute/writeback and drives the datapath mux selects and write strobes. ALU operation decode matches the single-cycle control path. Sits beside the instruction register; Op/funct3/funct7 come from the IR, and Zero comes from the ALU.

---
 rtl/multicycle_control_fsm_if.sv | 41 ++++
 rtl/multicycle_control_fsm.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle controller and the datapath (IR fields, ALU flag, selects, strobes).
// MC_CTRL_ILLEGAL_TRAP_EN adds the Illegal status line.
interface multicycle_control_fsm_if;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       InstrDone;
  logic [3:0] State;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  modport master (
    input  Op, funct3, funct7, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, State
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );

  modport slave (
    output Op, funct3, funct7, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, State
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unrecognised opcodes in a sticky ILLEGAL state.
module multicycle_control_fsm (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_control_fsm_if.master       bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , ILLEGAL = 4'd11
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       unused_funct7;

  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = ILLEGAL;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      JAL:      state_d = ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ILLEGAL:  state_d = ILLEGAL;
`endif
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_FUNCT;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALU_SUB: alu_control = 3'b001;
      ALU_FUNCT: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.Op[5] & bus.funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // The state register already reads FETCH during reset; strobes are masked so FETCH's enables stay quiet.
  assign bus.PCWrite    = ~rst & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = ~rst & ir_write;
  assign bus.MemWrite   = ~rst & mem_write;
  assign bus.RegWrite   = ~rst & reg_write;
  assign bus.InstrDone  = ~rst & instr_done;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.State      = state_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.Illegal    = (state_q == ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected outputs queued, then popped at each negedge.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the unrecognised-opcode case.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw, done, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] aluc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  obs_t        sb_q[$];
  logic [1:0]  cur_imm = 2'b00;
  string       cur_tag = "reset";

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.st   = bus.State;
    o.pcw  = bus.PCWrite;
    o.adr  = bus.AdrSrc;
    o.memw = bus.MemWrite;
    o.irw  = bus.IRWrite;
    o.regw = bus.RegWrite;
    o.done = bus.InstrDone;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    o.ill  = bus.Illegal;
`else
    o.ill  = 1'b0;
`endif
    o.rs   = bus.ResultSrc;
    o.sa   = bus.ALUSrcA;
    o.sb   = bus.ALUSrcB;
    o.imm  = bus.ImmSrc;
    o.aluc = bus.ALUControl;
    return o;
  endfunction

  // Expected outputs of each state taken from the state output table.
  function automatic obs_t exp_state(input logic [3:0] st, input logic [2:0] fn);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.imm = cur_imm;
    case (st)
      4'd0:  begin e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1'b1;
      4'd4:  begin e.rs = 2'b01; e.regw = 1'b1; e.done = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.memw = 1'b1; e.done = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.aluc = fn; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aluc = fn; end
      4'd8:  begin e.regw = 1'b1; e.done = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.aluc = 3'b001; e.pcw = bus.Zero; e.done = 1'b1; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd11: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t exp_reset();
    obs_t e;
    e     = '0;
    e.sb  = 2'b10;
    e.rs  = 2'b10;
    e.imm = cur_imm;
    return e;
  endfunction

  task automatic push(input logic [3:0] st, input logic [2:0] fn = 3'b000);
    sb_q.push_back(exp_state(st, fn));
  endtask

  task automatic set_ir(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic z, input logic [1:0] imm);
    cur_tag    = tag;
    bus.Op     = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.Zero   = z;
    cur_imm    = imm;
  endtask

  task automatic check_now();
    obs_t e, o;
    o = sample();
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: scoreboard empty, observed state %0d", cur_tag, o.st);
      return;
    end
    e = sb_q.pop_front();
    assert (o.st === e.st) else begin
      mismatched++;
      $error("FAIL %s.state: observed %0d expected %0d", cur_tag, o.st, e.st);
    end
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s.ctrl@st%0d: observed %h expected %h", cur_tag, e.st, o, e);
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    set_ir("reset", 7'b0000000, 3'b000, 7'b0000000, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_q.push_back(exp_reset());
    check_now();
    @(posedge clk);
    #1 rst = 1'b0;

    set_ir("lw", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(2); push(3); push(4);
    run(5);

    set_ir("r_sub", 7'b0110011, 3'b000, 7'b0100000, 1'b1, 2'b00);
    push(0); push(1); push(6, 3'b001); push(8);
    run(4);

    set_ir("r_add", 7'b0110011, 3'b000, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(6, 3'b000); push(8);
    run(4);

    set_ir("r_slt", 7'b0110011, 3'b010, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(6, 3'b101); push(8);
    run(4);

    set_ir("r_or", 7'b0110011, 3'b110, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(6, 3'b011); push(8);
    run(4);

    set_ir("r_and", 7'b0110011, 3'b111, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(6, 3'b010); push(8);
    run(4);

    set_ir("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 1'b1, 2'b00);
    push(0); push(1); push(7, 3'b000); push(8);
    run(4);

    set_ir("beq_taken", 7'b1100011, 3'b000, 7'b0000000, 1'b1, 2'b10);
    push(0); push(1); push(9);
    run(3);

    set_ir("beq_not", 7'b1100011, 3'b000, 7'b0000000, 1'b0, 2'b10);
    push(0); push(1); push(9);
    run(3);

    set_ir("jal", 7'b1101111, 3'b000, 7'b0000000, 1'b0, 2'b11);
    push(0); push(1); push(10); push(8);
    run(4);

    set_ir("sw", 7'b0100011, 3'b010, 7'b0000000, 1'b0, 2'b01);
    push(0); push(1); push(2); push(5);
    run(4);

    set_ir("sw_rst", 7'b0100011, 3'b010, 7'b0000000, 1'b1, 2'b01);
    push(0); push(1); push(2);
    run(3);
    @(negedge clk);
    push(5);
    check_now();
    #2 rst = 1'b1;
    #1;
    sb_q.push_back(exp_reset());
    check_now();
    @(posedge clk);
    #1 rst = 1'b0;
    cur_tag = "post_rst";
    push(0); push(1); push(2); push(5);
    run(4);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    set_ir("illegal", 7'b1111111, 3'b000, 7'b0000000, 1'b1, 2'b00);
    push(0); push(1); push(11); push(11); push(11);
    run(5);
    rst = 1'b1;
    #1;
    sb_q.push_back(exp_reset());
    check_now();
    @(posedge clk);
    #1 rst = 1'b0;
    cur_tag = "after_illegal";
    push(0);
    run(1);
`else
    set_ir("illegal_nop", 7'b1111111, 3'b000, 7'b0000000, 1'b1, 2'b00);
    push(0); push(1);
    run(2);
    set_ir("after_nop", 7'b0010011, 3'b111, 7'b0000000, 1'b0, 2'b00);
    push(0); push(1); push(7, 3'b010); push(8);
    run(4);
`endif

    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL leftover: observed %0d queued entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
